fir_interp_x4: RTL

Transmit-side counterpart of the single-rate receive FIR. This is a 16-tap polyphase interpolator that upsamples a low-rate signed sample stream by 4 (zero-stuff plus lowpass in one structure). It emits one filtered output sample per output-rate strobe. It sits ahead of the DAC/modulator path and consumes one input sample every 4th strobe.

---
 rtl/fir_interp_pkg.sv | 58 +++++
 rtl/interp_sat_trunc.sv | 35 +++
 rtl/fir_interp_x4.sv | 116 +++++++++++
 3 files changed

// File: rtl/fir_interp_pkg.sv
// -----------------------------------------------------------------------------
// fir_interp_pkg
// Shared constants for the x4 polyphase interpolator: the 16-tap lowpass
// prototype (S(8,7), each polyphase branch sums to 120), datapath widths,
// truncation/saturation limits and a coefficient lookup helper.
// -----------------------------------------------------------------------------
package fir_interp_pkg;

    localparam int WW_COEFF  = 8;     // S(8,7) coefficients, fixed for all instances
    localparam int WW_PROD   = 16;    // S(16,14) sample * coefficient product
    localparam int WW_SUM    = 18;    // S(18,14) four-product sum, cannot overflow
    localparam int TRUNC_LSB = 7;     // fractional bits dropped to return to S(.,7)
    localparam int SAT_MAX   = 127;
    localparam int SAT_MIN   = -128;
    localparam int N_PHASE   = 4;     // interpolation factor / taps per branch

    typedef logic [1:0] phase_t;

    localparam logic signed [WW_COEFF-1:0] H0  =  8'sd0;
    localparam logic signed [WW_COEFF-1:0] H1  = -8'sd3;
    localparam logic signed [WW_COEFF-1:0] H2  = -8'sd6;
    localparam logic signed [WW_COEFF-1:0] H3  =  8'sd0;
    localparam logic signed [WW_COEFF-1:0] H4  =  8'sd18;
    localparam logic signed [WW_COEFF-1:0] H5  =  8'sd48;
    localparam logic signed [WW_COEFF-1:0] H6  =  8'sd81;
    localparam logic signed [WW_COEFF-1:0] H7  =  8'sd102;
    localparam logic signed [WW_COEFF-1:0] H8  =  8'sd102;
    localparam logic signed [WW_COEFF-1:0] H9  =  8'sd81;
    localparam logic signed [WW_COEFF-1:0] H10 =  8'sd48;
    localparam logic signed [WW_COEFF-1:0] H11 =  8'sd18;
    localparam logic signed [WW_COEFF-1:0] H12 =  8'sd0;
    localparam logic signed [WW_COEFF-1:0] H13 = -8'sd6;
    localparam logic signed [WW_COEFF-1:0] H14 = -8'sd3;
    localparam logic signed [WW_COEFF-1:0] H15 =  8'sd0;

    // Prototype tap h[idx]; callers form idx as {branch tap k, phase p} = 4k+p.
    function automatic logic signed [WW_COEFF-1:0] coeff(input logic [3:0] idx);
        case (idx)
            4'd0:  return H0;
            4'd1:  return H1;
            4'd2:  return H2;
            4'd3:  return H3;
            4'd4:  return H4;
            4'd5:  return H5;
            4'd6:  return H6;
            4'd7:  return H7;
            4'd8:  return H8;
            4'd9:  return H9;
            4'd10: return H10;
            4'd11: return H11;
            4'd12: return H12;
            4'd13: return H13;
            4'd14: return H14;
            4'd15: return H15;
        endcase
    endfunction

endpackage

// File: rtl/interp_sat_trunc.sv
// -----------------------------------------------------------------------------
// interp_sat_trunc
// Combinational S(18,14) -> S(WW_OUT,7) conversion: floor truncation of the
// fractional LSBs followed by saturation to [SAT_MIN, SAT_MAX].
//   sum : signed accumulator value, S(18,14)
//   y   : signed saturated result
// -----------------------------------------------------------------------------
module interp_sat_trunc
    import fir_interp_pkg::*;
#(
    parameter int WW_OUT = 8
) (
    input  logic signed [WW_SUM-1:0] sum,
    output logic signed [WW_OUT-1:0] y
);

    localparam int SHW = WW_SUM - TRUNC_LSB;

    logic signed [SHW-1:0] shifted;

    // NOTE: every signal written here gets a value on every path (default
    // first), otherwise synthesis infers a latch.
    always_comb begin
        // Dropping the LSBs of a two's-complement value is an arithmetic
        // shift, i.e. a floor toward minus infinity.
        shifted = sum[WW_SUM-1:TRUNC_LSB];
        y       = shifted[WW_OUT-1:0];
        if (shifted > SAT_MAX) begin
            y = WW_OUT'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            y = WW_OUT'(SAT_MIN);
        end
    end

endmodule

// File: rtl/fir_interp_x4.sv
// -----------------------------------------------------------------------------
// fir_interp_x4
// 16-tap polyphase interpolate-by-4 FIR. One filtered output per i_en strobe;
// a new input sample is consumed on every 4th strobe (phase 0). Three-stage
// pipeline (products, sum, truncate/saturate) with a valid bit riding along.
//   clk        : system clock
//   i_rst_n    : asynchronous active-low reset
//   i_en       : output-rate strobe, gaps allowed
//   i_data     : signed input sample, taken when i_en && o_in_ready
//   o_in_ready : phase 0, next strobe consumes i_data
//   o_data     : signed filtered output, holds between o_valid pulses
//   o_valid    : one-cycle pulse, 3 cycles after the strobe
// -----------------------------------------------------------------------------
module fir_interp_x4
    import fir_interp_pkg::*;
#(
    parameter int WW_INPUT  = 8,
    parameter int WW_OUTPUT = 8
) (
    input  logic                        clk,
    input  logic                        i_rst_n,
    input  logic                        i_en,
    input  logic signed [WW_INPUT-1:0]  i_data,
    output logic                        o_in_ready,
    output logic signed [WW_OUTPUT-1:0] o_data,
    output logic                        o_valid
);

    phase_t                     phase_q;
    logic signed [WW_INPUT-1:0] x_q    [N_PHASE];
    logic signed [WW_INPUT-1:0] tap    [N_PHASE];
    logic signed [WW_PROD-1:0]  prod_d [N_PHASE];
    logic signed [WW_PROD-1:0]  s1_prod[N_PHASE];
    logic                       s1_valid;
    logic signed [WW_SUM-1:0]   sum_d;
    logic signed [WW_SUM-1:0]   s2_sum;
    logic                       s2_valid;
    logic signed [WW_OUTPUT-1:0] sat_y;

    assign o_in_ready = (phase_q == 2'd0);

    // Branch taps, newest first. At phase 0 the incoming sample is used in the
    // same cycle it is captured, so the older taps come from the not-yet-shifted
    // delay line; on phases 1..3 the delay line already holds that sample.
    always_comb begin
        for (int k = 0; k < N_PHASE; k++) begin
            tap[k] = x_q[k];
        end
        if (phase_q == 2'd0) begin
            tap[0] = i_data;
            for (int k = 1; k < N_PHASE; k++) begin
                tap[k] = x_q[k-1];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_PHASE; k++) begin
            prod_d[k] = WW_PROD'(tap[k]) * WW_PROD'(coeff({2'(k), phase_q}));
        end
        sum_d = WW_SUM'(s1_prod[0]) + WW_SUM'(s1_prod[1])
              + WW_SUM'(s1_prod[2]) + WW_SUM'(s1_prod[3]);
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    // NOTE: the delay line is reset along with the pipeline so no stale
    // samples leak into the first outputs after a reset.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase_q <= '0;
            for (int k = 0; k < N_PHASE; k++) begin
                x_q[k] <= '0;
            end
        end else if (i_en) begin
            phase_q <= phase_q + 2'd1;
            if (phase_q == 2'd0) begin
                x_q[0] <= i_data;
                for (int k = 1; k < N_PHASE; k++) begin
                    x_q[k] <= x_q[k-1];
                end
            end
        end
    end

    // Pipeline stages clock every cycle; only the valid bit qualifies data.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_PHASE; k++) begin
                s1_prod[k] <= '0;
            end
            s1_valid <= 1'b0;
            s2_sum   <= '0;
            s2_valid <= 1'b0;
            o_data   <= '0;
            o_valid  <= 1'b0;
        end else begin
            s1_prod  <= prod_d;
            s1_valid <= i_en;
            s2_sum   <= sum_d;
            s2_valid <= s1_valid;
            o_valid  <= s2_valid;
            if (s2_valid) begin
                o_data <= sat_y;
            end
        end
    end

    interp_sat_trunc #(
        .WW_OUT (WW_OUTPUT)
    ) u_sat (
        .sum (s2_sum),
        .y   (sat_y)
    );

endmodule
